program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameters: none; program store fixed at 16 words x 3 bits.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 load_start  input  1  one-cycle pulse; begin (or restart) a program load.
REQ-005 in_valid  input  1  in_data/in_last carry a program word this cycle.
REQ-006 in_data  input  3  program word (opcode or operand).
REQ-007 in_last  input  1  qualifies in_data as final program word.
REQ-008 in_ready  output  1  registered; loader accepts a word this cycle.
REQ-009 load_done  output  1  registered; program store valid and readable.
REQ-010 prog_len  output  5  registered; words stored, 0..16.
REQ-011 rd_ptr  input  4  instruction pointer from the fetch stage.
REQ-012 rd_opcode  output  3  combinational; word at rd_ptr.
REQ-013 rd_operand  output  3  combinational; word at rd_ptr+1.
REQ-014 rd_end  output  1  combinational; rd_ptr at or beyond end of loaded program.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, DONE; in_ready = (state==LOAD); load_done = (state==DONE).
REQ-016 IDLE: load_start=1 SHALL go to LOAD, clear all 16 words to 3'b000, set wr_ptr=0, prog_len=0.
REQ-017 LOAD: handshake = in_valid && in_ready; on handshake SHALL write in_data to word[wr_ptr], increment wr_ptr and prog_len.
REQ-018 LOAD: no in_valid SHALL leave all state unchanged; no timeout.
REQ-019 LOAD: handshake with in_last=1 SHALL go to DONE next cycle; in_ready drops the same edge.
REQ-020 LOAD: handshake at wr_ptr=15 SHALL go to DONE regardless of in_last (prog_len=16); no wrap, no overwrite of word 0.
REQ-021 load_start=1 in LOAD or DONE SHALL restart as in REQ-016; a simultaneous handshake SHALL be discarded (start wins).
REQ-022 DONE: in_valid SHALL be ignored; store and prog_len held until load_start or reset.
REQ-023 Write latency: a word accepted at edge N SHALL be readable via rd_* after edge N only once load_done=1.
REQ-024 Read, state==DONE and rd_ptr even: rd_opcode=word[rd_ptr], rd_operand=word[rd_ptr+1].
REQ-025 Read, rd_ptr odd or state!=DONE: rd_opcode=rd_operand=3'b000.
REQ-026 rd_end SHALL be 1 when state!=DONE or {1'b0,rd_ptr}+1 >= prog_len (no complete opcode/operand pair), else 0.
REQ-027 Odd prog_len: the trailing unpaired word SHALL be stored; its pair reads operand 3'b000 and rd_end=1.
REQ-028 prog_len SHALL saturate at 16; wr_ptr SHALL never exceed 15.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, all words=3'b000, wr_ptr=0, prog_len=0, in_ready=0, load_done=0.
REQ-030 Reset during LOAD SHALL abandon the load; no partial words survive; rd_end=1, rd_* = 0.
REQ-031 After rst_n deasserts, no load SHALL start without a load_start pulse.

Verification
REQ-032 Reset, pulse load_start, stream 2,4,1,1,7,5,0,3 (in_last on 3) -> load_done=1, prog_len=8; rd_ptr=2 -> opcode 1, operand 1, rd_end=0; rd_ptr=6 -> 0,3, rd_end=0; rd_ptr=8 -> rd_end=1.
REQ-033 Stream 17 words with in_valid held, no in_last -> 16 accepted, DONE after 16th, prog_len=16, 17th ignored, word 0 unchanged.
REQ-034 Gaps: in_valid toggling 1,0,0,1,... over 4 words -> only handshake cycles write; prog_len=4; rd_ptr=1 -> outputs 0.
REQ-035 load_start asserted in same cycle as handshake of word 3 -> word discarded, store cleared, prog_len=0, in_ready=1 next cycle.
REQ-036 Assert rst_n=0 mid-load after 5 words -> same-cycle in_ready=0, load_done=0, prog_len=0; subsequent reads all 0.
REQ-037 Odd length 0,1,5 (in_last on 5) -> prog_len=3; rd_ptr=2 -> opcode 5, operand 0, rd_end=1; rd_ptr=0 -> 0,1, rd_end=0.

Source files
------------

// File: rtl/program_loader.sv
// Program loader: accepts a stream of 3-bit program words into a 16-entry
// store, then exposes opcode/operand pairs to the fetch stage once loaded.
module program_loader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_start,
    input  logic       in_valid,
    input  logic [2:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       load_done,
    output logic [4:0] prog_len,
    input  logic [3:0] rd_ptr,
    output logic [2:0] rd_opcode,
    output logic [2:0] rd_operand,
    output logic       rd_end
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_nxt;
    logic [15:0][2:0]  words;
    logic [3:0]        wr_ptr;
    logic              hs;
    logic              last_word;

    // A restart pulse always wins over a word offered in the same cycle.
    assign hs        = in_valid && in_ready && !load_start;
    // The store fills at word 15; that word terminates the load even without in_last.
    assign last_word = in_last || (wr_ptr == 4'd15);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load_start) state_nxt = LOAD;
            LOAD: begin
                if (load_start)            state_nxt = LOAD;
                else if (hs && last_word)  state_nxt = DONE;
            end
            DONE: if (load_start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered status flags track the state they will reflect next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            load_done <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == LOAD);
            load_done <= (state_nxt == DONE);
        end
    end

    // Program store, write pointer and length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words    <= '0;
            wr_ptr   <= 4'd0;
            prog_len <= 5'd0;
        end else if (load_start) begin
            words    <= '0;
            wr_ptr   <= 4'd0;
            prog_len <= 5'd0;
        end else if (hs) begin
            words[wr_ptr] <= in_data;
            if (wr_ptr != 4'd15)    wr_ptr   <= wr_ptr + 4'd1;
            if (prog_len != 5'd16)  prog_len <= prog_len + 5'd1;
        end
    end

    // Read port: only even pointers address an opcode/operand pair, and only
    // a completed load is visible to the fetch stage.
    always_comb begin
        rd_opcode  = 3'b000;
        rd_operand = 3'b000;
        if (state == DONE && !rd_ptr[0]) begin
            rd_opcode  = words[rd_ptr];
            rd_operand = words[{rd_ptr[3:1], 1'b1}];
        end
        rd_end = (state != DONE) || (({1'b0, rd_ptr} + 5'd1) >= prog_len);
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a queue-based program model predicts
// load completion and read-port values; a monitor compares against the DUT.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_data = 3'd0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       load_done;
    logic [4:0] prog_len;
    logic [3:0] rd_ptr = 4'd0;
    logic [2:0] rd_opcode;
    logic [2:0] rd_operand;
    logic       rd_end;

    program_loader dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .load_done(load_done), .prog_len(prog_len),
        .rd_ptr(rd_ptr), .rd_opcode(rd_opcode), .rd_operand(rd_operand),
        .rd_end(rd_end)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2;

    int         n_chk = 0;
    int         n_fail = 0;
    int         prog[$];
    int         m_st = M_IDLE;
    int         done_q[$];
    logic [6:0] rd_q[$];
    logic       rd_probe = 1'b0;
    logic       ld_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model applies the same inputs at the edge.
    task automatic cycle(input bit st, input bit v, input logic [2:0] d, input bit last);
        load_start = st; in_valid = v; in_data = d; in_last = last;
        chk("in_ready", in_ready, m_st == M_LOAD);
        chk("load_done", load_done, m_st == M_DONE);
        chk("prog_len", prog_len, prog.size());
        @(posedge clk);
        if (st) begin
            prog.delete();
            m_st = M_LOAD;
        end else if (m_st == M_LOAD && v) begin
            prog.push_back(int'(d));
            if (last || prog.size() == 16) begin
                m_st = M_DONE;
                done_q.push_back(prog.size());
            end
        end
        #1;
        load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Present a read pointer; the expected pair comes from the program list.
    task automatic rd_check(input int p);
        int op, oper, e, n;
        n = prog.size();
        op = 0; oper = 0; e = 1;
        if (m_st == M_DONE) begin
            e = (p + 1 >= n) ? 1 : 0;
            if (p % 2 == 0) begin
                op   = (p < n) ? prog[p] : 0;
                oper = (p + 1 < n) ? prog[p + 1] : 0;
            end
        end
        rd_ptr = 4'(p);
        rd_q.push_back({op[2:0], oper[2:0], e[0]});
        rd_probe = 1'b1;
        @(posedge clk);
        #1 rd_probe = 1'b0;
    endtask

    task automatic send(input int d, input bit last);
        cycle(1'b0, 1'b1, 3'(d), last);
    endtask

    // Monitor: compares whenever a read is probed or load_done rises.
    always @(negedge clk) begin
        if (rd_probe) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_pair", {rd_opcode, rd_operand, rd_end}, rd_q.pop_front());
        end
        if (rst_n && load_done && !ld_prev) begin
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_len", prog_len, done_q.pop_front());
        end
        ld_prev <= load_done;
    end

    initial begin
        int len;
        int pat[8];
        // Reset state
        #12;
        chk("rst_ready", in_ready, 0);
        chk("rst_done", load_done, 0);
        chk("rst_len", prog_len, 0);
        chk("rst_end", rd_end, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        // No load without a start pulse
        repeat (3) send(5, 1'b0);

        // Basic 8-word program
        pat = '{2, 4, 1, 1, 7, 5, 0, 3};
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) send(pat[i], i == 7);
        rd_check(2); rd_check(6); rd_check(8); rd_check(0);

        // 17 words, no in_last: store fills at 16, 17th ignored
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 17; i++) send((i + 3) % 8, 1'b0);
        rd_check(0); rd_check(14); rd_check(15);

        // Gapped stream of 4 words
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send(7 - i, i == 3);
            if (i < 3) begin
                cycle(1'b0, 1'b0, 3'd6, 1'b1);
                cycle(1'b0, 1'b0, 3'd6, 1'b1);
            end
        end
        rd_check(1); rd_check(0); rd_check(2);

        // Restart colliding with the handshake of word 3
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0);
        cycle(1'b1, 1'b1, 3'd6, 1'b0);
        send(4, 1'b0); send(5, 1'b1);
        rd_check(0); rd_check(2);

        // Reset mid-load after 5 words
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) send(i + 1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_done", load_done, 0);
        chk("mid_rst_len", prog_len, 0);
        prog.delete();
        m_st = M_IDLE;
        @(posedge clk); #1 rst_n = 1'b1;
        rd_check(0); rd_check(2);
        send(3, 1'b1);

        // Odd-length program
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        send(0, 1'b0); send(1, 1'b0); send(5, 1'b1);
        rd_check(2); rd_check(0); rd_check(3);

        // Randomized programs with gaps and ignored trailing words
        for (int t = 0; t < 20; t++) begin
            len = $urandom_range(1, 17);
            cycle(1'b1, 1'b0, 3'd0, 1'b0);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 3'($urandom), 1'($urandom));
                send($urandom_range(0, 7), (i == len - 1) && (len <= 16));
            end
            send($urandom_range(0, 7), 1'b1);
            for (int k = 0; k < 5; k++) rd_check($urandom_range(0, 15));
            rd_check((len > 16 ? 16 : len) - 1);
        end

        repeat (3) @(posedge clk);
        chk("pending_done", done_q.size(), 0);
        chk("pending_rd", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
